orb_frame_buffer: RTL and testbench

Ping-pong frame buffer that feeds the orbit serializer. Collects 11-bit telemetry words from the acquisition side through a valid/ready stream and writes them into the bank the serializer is not reading. Serves the serializer's registered read port (address, read enable, bank select) with one-clock read latency and a held output. Reports fill level, early swap (underflow) and dropped words (overflow).

---
 rtl/orb_pkg.sv | 30 +++
 rtl/orb_frame_buffer_dpram.sv | 37 +++
 rtl/orb_frame_buffer.sv | 107 ++++++++++
 tb/tb_orb_frame_buffer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/orb_pkg.sv
// Shared constants and types for the orbit serializer path.
// The frame buffer and the serializer both import this package so word
// width, marker position and frame length are defined in one place.
package orb_pkg;

    localparam int WORDS_PER_FRAME = 2048;
    localparam int ORB_ADDR_W      = 11;
    localparam int ORB_WORD_W      = 12;
    localparam int MARKER_BIT      = 11;

    // Telemetry words occupy the bits below the marker.
    localparam int ORB_DATA_W      = MARKER_BIT;

    typedef logic [ORB_WORD_W-1:0] orbWord_t;
    typedef logic [ORB_DATA_W-1:0] orbData_t;

    // Status flags the frame buffer reports to the serializer side.
    typedef struct packed {
        logic swap;
        logic underflow;
        logic overflow;
    } orbFlags_t;

    // Stored words keep the marker bit clear; the serializer ORs its
    // marker into bit MARKER_BIT on the way out.
    function automatic orbWord_t packWord(input orbData_t data);
        return {1'b0, data};
    endfunction

endpackage

// File: rtl/orb_frame_buffer_dpram.sv
// Simple dual-port RAM holding both ping-pong banks.
// One write port, one registered read port with enable; the read
// register holds its value while the enable is low so the serializer can
// sample it several clocks later.
module orb_dpram #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 12
) (
    input  logic              iClkOrb,
    input  logic              reset,
    input  logic              iWrEn,
    input  logic [ADDR_W-1:0] iWrAddr,
    input  logic [DATA_W-1:0] iWrData,
    input  logic              iRdEn,
    input  logic [ADDR_W-1:0] iRdAddr,
    output logic [DATA_W-1:0] oRdData
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    // Write port; contents are intentionally not reset.
    always_ff @(posedge iClkOrb) begin
        if (iWrEn) begin
            mem[iWrAddr] <= iWrData;
        end
    end

    // Registered read port, held when not enabled.
    always_ff @(posedge iClkOrb or negedge reset) begin
        if (!reset) begin
            oRdData <= '0;
        end else if (iRdEn) begin
            oRdData <= mem[iRdAddr];
        end
    end

endmodule

// File: rtl/orb_frame_buffer.sv
// Ping-pong frame buffer feeding the orbit serializer.
// The acquisition stream fills the bank the serializer is not reading;
// a change on iSwitch swaps banks, restarts the writer at address 0 and
// reports whether the outgoing frame was complete.
module orb_frame_buffer
    import orb_pkg::*;
#(
    parameter int ADDR_W = ORB_ADDR_W,
    parameter int DEPTH  = WORDS_PER_FRAME
) (
    input  logic                  iClkOrb,
    input  logic                  reset,
    input  logic [ORB_DATA_W-1:0] iData,
    input  logic                  iValid,
    output logic                  oReady,
    input  logic [ADDR_W-1:0]     iAddr,
    input  logic                  iRdEn,
    input  logic                  iSwitch,
    output logic [ORB_WORD_W-1:0] oWord,
    output logic [ADDR_W:0]       oFill,
    output logic                  oSwap,
    output logic                  oUnderflow,
    output logic                  oOverflow
);

    localparam logic [ADDR_W:0] FILL_FULL = (ADDR_W+1)'(DEPTH);

    logic              swPrev;
    logic [ADDR_W-1:0] wrPtr;
    logic [ADDR_W:0]   fill;
    orbFlags_t         flags;
    logic              swapEvent;
    logic              full;
    logic              wrEn;
    logic [ADDR_W:0]   wrAddr;
    logic [ADDR_W:0]   rdAddr;

    // The swap cycle is the one where the serializer's bank select differs
    // from our registered copy; no write is taken in that cycle so the new
    // write bank always starts cleanly at address 0.
    assign swapEvent = (iSwitch != swPrev);
    assign full      = (fill == FILL_FULL);
    assign oReady    = reset && !full && !swapEvent;
    assign wrEn      = iValid && oReady;

    // Write bank is the complement of the bank the serializer reads.
    assign wrAddr = {~swPrev, wrPtr};
    assign rdAddr = {iSwitch, iAddr};

    // Registered copy of the serializer's bank select.
    always_ff @(posedge iClkOrb or negedge reset) begin
        if (!reset) begin
            swPrev <= 1'b0;
        end else begin
            swPrev <= iSwitch;
        end
    end

    // Write pointer and fill level; both restart on a swap.
    always_ff @(posedge iClkOrb or negedge reset) begin
        if (!reset) begin
            wrPtr <= '0;
            fill  <= '0;
        end else if (swapEvent) begin
            wrPtr <= '0;
            fill  <= '0;
        end else if (wrEn) begin
            wrPtr <= wrPtr + ADDR_W'(1);
            fill  <= fill + (ADDR_W+1)'(1);
        end
    end

    // Swap/underflow pulses and the sticky overflow flag.
    always_ff @(posedge iClkOrb or negedge reset) begin
        if (!reset) begin
            flags <= '0;
        end else begin
            flags.swap      <= swapEvent;
            flags.underflow <= swapEvent && !full;
            if (swapEvent) begin
                flags.overflow <= 1'b0;
            end else if (iValid && full) begin
                flags.overflow <= 1'b1;
            end
        end
    end

    assign oFill      = fill;
    assign oSwap      = flags.swap;
    assign oUnderflow = flags.underflow;
    assign oOverflow  = flags.overflow;

    orb_dpram #(
        .ADDR_W (ADDR_W + 1),
        .DATA_W (ORB_WORD_W)
    ) uRam (
        .iClkOrb (iClkOrb),
        .reset   (reset),
        .iWrEn   (wrEn),
        .iWrAddr (wrAddr),
        .iWrData (packWord(iData)),
        .iRdEn   (iRdEn),
        .iRdAddr (rdAddr),
        .oRdData (oWord)
    );

endmodule

// File: tb/tb_orb_frame_buffer.sv
// Directed bench for orb_frame_buffer: full frame, partial frame with
// underflow, overflow at full, valid held across a swap, reset mid-fill
// and read-data hold.
module tb_orb_frame_buffer;
    import orb_pkg::*;

    logic        iClkOrb = 1'b0;
    logic        reset   = 1'b1;
    logic [10:0] iData   = '0;
    logic        iValid  = 1'b0;
    logic [10:0] iAddr   = '0;
    logic        iRdEn   = 1'b0;
    logic        iSwitch = 1'b0;
    logic        oReady;
    logic [11:0] oWord;
    logic [11:0] oFill;
    logic        oSwap;
    logic        oUnderflow;
    logic        oOverflow;

    int nChk  = 0;
    int nPass = 0;

    orb_frame_buffer dut (
        .iClkOrb    (iClkOrb),
        .reset      (reset),
        .iData      (iData),
        .iValid     (iValid),
        .oReady     (oReady),
        .iAddr      (iAddr),
        .iRdEn      (iRdEn),
        .iSwitch    (iSwitch),
        .oWord      (oWord),
        .oFill      (oFill),
        .oSwap      (oSwap),
        .oUnderflow (oUnderflow),
        .oOverflow  (oOverflow)
    );

    always #5 iClkOrb = ~iClkOrb;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChk++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge iClkOrb);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic readWord(input logic [10:0] addr, input logic [11:0] exp, input string tag);
        iAddr = addr;
        iRdEn = 1'b1;
        step();
        iRdEn = 1'b0;
        checkVal(tag, 32'(oWord), 32'(exp));
    endtask

    initial begin
        // reset state
        #2 reset = 1'b0;
        step();
        step();
        checkVal("rst oReady", 32'(oReady), 0);
        checkVal("rst oWord", 32'(oWord), 0);
        checkVal("rst oFill", 32'(oFill), 0);
        checkVal("rst oSwap", 32'(oSwap), 0);
        checkVal("rst oUnderflow", 32'(oUnderflow), 0);
        checkVal("rst oOverflow", 32'(oOverflow), 0);
        reset = 1'b1;
        settle();
        checkVal("ready after release", 32'(oReady), 1);

        // full frame 0..2047 into bank 1
        for (int i = 0; i < 2048; i++) begin
            iData  = 11'(i);
            iValid = 1'b1;
            step();
        end
        iValid = 1'b0;
        checkVal("full fill", 32'(oFill), 2048);
        checkVal("full ready", 32'(oReady), 0);
        checkVal("full no overflow", 32'(oOverflow), 0);
        iSwitch = 1'b1;
        settle();
        checkVal("swap cycle ready", 32'(oReady), 0);
        step();
        checkVal("swap pulse", 32'(oSwap), 1);
        checkVal("full swap underflow", 32'(oUnderflow), 0);
        checkVal("fill after swap", 32'(oFill), 0);
        checkVal("ready after swap", 32'(oReady), 1);
        step();
        checkVal("swap pulse end", 32'(oSwap), 0);
        readWord(11'd0, 12'h000, "read addr 0");
        readWord(11'd5, 12'h005, "read addr 5");
        readWord(11'd2047, 12'h7FF, "read addr 2047");

        // partial frame of 100 words into bank 0, then underflow swap
        for (int j = 0; j < 100; j++) begin
            iData  = (j == 0) ? 11'h7FF : 11'(j + 'h100);
            iValid = 1'b1;
            step();
        end
        iValid = 1'b0;
        checkVal("partial fill", 32'(oFill), 100);
        iSwitch = 1'b0;
        step();
        checkVal("underflow pulse", 32'(oUnderflow), 1);
        checkVal("underflow swap", 32'(oSwap), 1);
        checkVal("underflow fill", 32'(oFill), 0);
        step();
        checkVal("underflow pulse end", 32'(oUnderflow), 0);
        readWord(11'd0, 12'h7FF, "max data word");
        checkVal("marker bit clear", 32'(oWord[11]), 0);
        readWord(11'd99, 12'h163, "partial last word");

        // fill bank 1 again, then hold valid while full
        for (int k = 0; k < 2048; k++) begin
            iData  = (k == 0) ? 11'h123 : 11'((k * 3) & 'h7FF);
            iValid = 1'b1;
            step();
        end
        iData = 11'h3FF;
        repeat (10) step();
        checkVal("overflow ready", 32'(oReady), 0);
        checkVal("overflow flag", 32'(oOverflow), 1);
        checkVal("overflow fill", 32'(oFill), 2048);
        iValid  = 1'b0;
        iSwitch = 1'b1;
        settle();
        checkVal("overflow swap cycle ready", 32'(oReady), 0);
        step();
        checkVal("overflow cleared", 32'(oOverflow), 0);
        checkVal("overflow swap underflow", 32'(oUnderflow), 0);
        checkVal("overflow ready back", 32'(oReady), 1);
        readWord(11'd0, 12'h123, "restart addr 0");
        readWord(11'd1, 12'h003, "second word");
        readWord(11'd2047, 12'h7FD, "last word");

        // valid held high across a toggle (writing bank 0)
        iValid = 1'b1;
        for (int n = 0; n < 5; n++) begin
            iData = 11'('h400 + n);
            step();
        end
        iData   = 11'h405;
        iSwitch = 1'b0;
        settle();
        checkVal("toggle ready", 32'(oReady), 0);
        step();
        checkVal("toggle fill", 32'(oFill), 0);
        checkVal("toggle overflow", 32'(oOverflow), 0);
        checkVal("toggle underflow", 32'(oUnderflow), 1);
        iData = 11'h406;
        step();
        checkVal("toggle next accepted", 32'(oFill), 1);
        iValid  = 1'b0;
        iSwitch = 1'b1;
        step();
        step();
        readWord(11'd0, 12'h406, "first after toggle");
        readWord(11'd1, 12'h003, "stale word kept");

        // reset mid-fill (writing bank 0)
        for (int m = 0; m < 500; m++) begin
            iData  = 11'('h200 + m);
            iValid = 1'b1;
            step();
        end
        iValid = 1'b0;
        checkVal("mid fill", 32'(oFill), 500);
        reset   = 1'b0;
        iSwitch = 1'b0;
        settle();
        checkVal("mid rst oWord", 32'(oWord), 0);
        checkVal("mid rst oFill", 32'(oFill), 0);
        checkVal("mid rst oReady", 32'(oReady), 0);
        checkVal("mid rst oSwap", 32'(oSwap), 0);
        checkVal("mid rst oUnderflow", 32'(oUnderflow), 0);
        checkVal("mid rst oOverflow", 32'(oOverflow), 0);
        step();
        reset = 1'b1;
        settle();
        checkVal("post rst ready", 32'(oReady), 1);
        iData  = 11'h555;
        iValid = 1'b1;
        step();
        iValid = 1'b0;
        checkVal("post rst fill", 32'(oFill), 1);
        iSwitch = 1'b1;
        step();
        step();
        readWord(11'd0, 12'h555, "post rst bank1 addr0");
        iAddr = 11'd7;
        for (int h = 0; h < 20; h++) begin
            step();
            checkVal("oWord hold", 32'(oWord), 32'h555);
        end

        $display("%0d/%0d checks passed", nPass, nChk);
        $finish;
    end

endmodule
